// File: rtl/acs_pm_unit.sv
// Add-compare-select stage of a hard-decision rate-1/2 Viterbi decoder.
// Keeps one path metric per trellis state and emits survivor decisions plus the best state.
module acs_pm_unit #(
  parameter int M          = 6,
  parameter int NUM_STATES = 64,
  parameter int PM_W       = 7,
  parameter int INIT_PM    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [NUM_STATES*4-1:0]   bm_flat,
  output logic                      dec_valid,
  output logic [NUM_STATES-1:0]     dec_bits,
  output logic [M-1:0]              best_state,
  output logic [PM_W-1:0]           best_metric
);

  localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

  logic [NUM_STATES-1:0][PM_W-1:0] pm_reg;
  logic [NUM_STATES-1:0][PM_W-1:0] base_pm;
  logic [NUM_STATES-1:0][PM_W-1:0] sel_pm;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_next;
  logic [NUM_STATES-1:0]           dec_next;
  logic [NUM_STATES-1:0]           sel_msb;
  logic                            norm_all;

  logic                            dec_valid_reg;
  logic [NUM_STATES-1:0]           dec_bits_reg;
  logic [M-1:0]                    best_state_reg;
  logic [PM_W-1:0]                 best_metric_reg;

  genvar gi;
  genvar gl;

  // A start-of-frame step restarts from the reset metrics instead of the stored ones.
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_base
      localparam logic [PM_W-1:0] START_PM = (gi == 0) ? '0 : INIT_VAL;
      assign base_pm[gi] = in_sof ? START_PM : pm_reg[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_acs
      localparam int P0 = (2 * gi) % NUM_STATES;
      localparam int P1 = P0 + 1;

      logic [PM_W:0]   c0_sum;
      logic [PM_W:0]   c1_sum;
      logic [PM_W-1:0] c0_sat;
      logic [PM_W-1:0] c1_sat;

      assign c0_sum = {1'b0, base_pm[P0]} + {{(PM_W-1){1'b0}}, bm_flat[4*gi +: 2]};
      assign c1_sum = {1'b0, base_pm[P1]} + {{(PM_W-1){1'b0}}, bm_flat[4*gi+2 +: 2]};

      // Sums never exceed 2**(PM_W+1)-1, so the carry bit alone flags overflow.
      assign c0_sat = c0_sum[PM_W] ? '1 : c0_sum[PM_W-1:0];
      assign c1_sat = c1_sum[PM_W] ? '1 : c1_sum[PM_W-1:0];

      assign dec_next[gi] = (c1_sat < c0_sat);
      assign sel_pm[gi]   = dec_next[gi] ? c1_sat : c0_sat;
      assign sel_msb[gi]  = sel_pm[gi][PM_W-1];
      // Every metric has its MSB set when normalising, so subtraction is clearing it.
      assign pm_next[gi]  = norm_all ? {1'b0, sel_pm[gi][PM_W-2:0]} : sel_pm[gi];
    end
  endgenerate

  assign norm_all = &sel_msb;

  // Binary minimum tree; the left child holds lower state indices and wins ties.
  generate
    for (gl = 0; gl <= M; gl++) begin : lvl
      localparam int N = NUM_STATES >> gl;
      logic [N-1:0][PM_W-1:0] m;
      logic [N-1:0][M-1:0]    st;

      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < N; gi++) begin : g_node
          assign m[gi]  = pm_next[gi];
          assign st[gi] = M'(gi);
        end
      end else begin : g_inner
        for (gi = 0; gi < N; gi++) begin : g_node
          logic right_wins;
          assign right_wins = (lvl[gl-1].m[2*gi+1] < lvl[gl-1].m[2*gi]);
          assign m[gi]  = right_wins ? lvl[gl-1].m[2*gi+1]  : lvl[gl-1].m[2*gi];
          assign st[gi] = right_wins ? lvl[gl-1].st[2*gi+1] : lvl[gl-1].st[2*gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_reg[s] <= (s == 0) ? '0 : INIT_VAL;
      end
      dec_valid_reg   <= 1'b0;
      dec_bits_reg    <= '0;
      best_state_reg  <= '0;
      best_metric_reg <= '0;
    end else begin
      dec_valid_reg <= in_valid;
      if (in_valid) begin
        pm_reg          <= pm_next;
        dec_bits_reg    <= dec_next;
        best_state_reg  <= lvl[M].st[0];
        best_metric_reg <= lvl[M].m[0];
      end
    end
  end

  assign dec_valid   = dec_valid_reg;
  assign dec_bits    = dec_bits_reg;
  assign best_state  = best_state_reg;
  assign best_metric = best_metric_reg;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Self-checking bench for acs_pm_unit: directed vector table, hand sequences,
// and a randomized stream checked against an arithmetic trellis model.
module tb_acs_pm_unit;
  localparam int M    = 6;
  localparam int NS   = 64;
  localparam int PW   = 7;
  localparam int INIT = 16;
  localparam int BMW  = NS * 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [BMW-1:0] bm_flat = '0;
  logic           dec_valid;
  logic [NS-1:0]  dec_bits;
  logic [M-1:0]   best_state;
  logic [PW-1:0]  best_metric;

  always #5 clk = ~clk;

  acs_pm_unit #(.M(M), .NUM_STATES(NS), .PM_W(PW), .INIT_PM(INIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .bm_flat(bm_flat),
    .dec_valid(dec_valid), .dec_bits(dec_bits), .best_state(best_state),
    .best_metric(best_metric)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;

  // Reference model state
  int            ref_pm[NS];
  logic          ref_dv;
  logic [NS-1:0] ref_dec;
  int            ref_bs;
  int            ref_bm;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) ref_pm[s] = (s == 0) ? 0 : INIT;
    ref_dv  = 1'b0;
    ref_dec = '0;
    ref_bs  = 0;
    ref_bm  = 0;
  endfunction

  function automatic void model_step(input bit v, input bit sof, input logic [BMW-1:0] bm);
    int base[NS];
    int nw[NS];
    bit all_hi;
    int p0, p1, c0, c1, b0, b1;
    ref_dv = v;
    if (!v) return;
    all_hi = 1'b1;
    for (int s = 0; s < NS; s++) base[s] = sof ? ((s == 0) ? 0 : INIT) : ref_pm[s];
    for (int s = 0; s < NS; s++) begin
      p0 = (2 * s) % NS;
      p1 = p0 + 1;
      b0 = int'(bm[4*s +: 2]);
      b1 = int'(bm[4*s+2 +: 2]);
      c0 = base[p0] + b0;
      c1 = base[p1] + b1;
      if (c0 > 127) c0 = 127;
      if (c1 > 127) c1 = 127;
      ref_dec[s] = (c1 < c0);
      nw[s] = (c1 < c0) ? c1 : c0;
      if (nw[s] < 64) all_hi = 1'b0;
    end
    for (int s = 0; s < NS; s++) ref_pm[s] = all_hi ? nw[s] - 64 : nw[s];
    ref_bs = 0;
    ref_bm = ref_pm[0];
    for (int s = 1; s < NS; s++) begin
      if (ref_pm[s] < ref_bm) begin
        ref_bm = ref_pm[s];
        ref_bs = s;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dec_valid"},   64'(dec_valid),   64'(ref_dv));
    chk({tag, ".dec_bits"},    64'(dec_bits),    64'(ref_dec));
    chk({tag, ".best_state"},  64'(best_state),  64'(ref_bs));
    chk({tag, ".best_metric"}, 64'(best_metric), 64'(ref_bm));
  endtask

  // One clock: drive inputs, let the edge take them, advance the model, sample at +1.
  task automatic cyc(input bit r, input bit v, input bit sof, input logic [BMW-1:0] bm);
    rst = r; in_valid = v; in_sof = sof; bm_flat = bm;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_step(v, sof, bm);
    n_txn++;
    $display("txn %0d: rst=%0b v=%0b sof=%0b -> dv=%0b dec=%016h best=%0d/%0d",
             n_txn, r, v, sof, dec_valid, dec_bits, best_state, best_metric);
  endtask

  function automatic logic [BMW-1:0] rand_bm();
    logic [BMW-1:0] b;
    b = '0;
    for (int k = 0; k < NS * 2; k++) b[2*k +: 2] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  typedef struct {
    bit             r;
    bit             v;
    bit             sof;
    logic [BMW-1:0] bm;
    bit             exp_dv;
    logic [NS-1:0]  exp_dec;
    int             exp_bs;
    int             exp_bm;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl[NVEC];

  task automatic set_row(input int i, input bit r, input bit v, input bit sof,
                         input logic [BMW-1:0] bm, input bit edv,
                         input logic [NS-1:0] edec, input int ebs, input int ebm);
    tbl[i].r = r; tbl[i].v = v; tbl[i].sof = sof; tbl[i].bm = bm;
    tbl[i].exp_dv = edv; tbl[i].exp_dec = edec; tbl[i].exp_bs = ebs; tbl[i].exp_bm = ebm;
  endtask

  initial begin
    logic [BMW-1:0] zero_bm;
    logic [BMW-1:0] s1_bm;
    logic [BMW-1:0] tie_bm;
    logic [BMW-1:0] all2_bm;
    logic [BMW-1:0] best32_bm;
    logic [BMW-1:0] rb;
    bit gap_v[7];
    bit v, s, r;

    zero_bm   = '0;
    s1_bm     = BMW'(8'h20);          // state 1: bm0=2, bm1=0
    tie_bm    = BMW'(8'hA0);          // state 1: bm0=2, bm1=2
    all2_bm   = {NS{4'hA}};
    best32_bm = BMW'(4'hA) | (BMW'(1) << 128);  // state 0: 2/2, state 32: bm0=1

    set_row(0,  1, 0, 0, zero_bm,   0, '0,        0,  0);
    set_row(1,  0, 0, 0, zero_bm,   0, '0,        0,  0);
    set_row(2,  0, 1, 1, zero_bm,   1, '0,        0,  0);
    set_row(3,  0, 0, 0, zero_bm,   0, '0,        0,  0);
    set_row(4,  0, 1, 1, s1_bm,     1, NS'(2),    0,  0);
    set_row(5,  0, 0, 1, s1_bm,     0, NS'(2),    0,  0);
    set_row(6,  0, 1, 1, tie_bm,    1, '0,        0,  0);
    set_row(7,  0, 1, 1, s1_bm,     1, NS'(2),    0,  0);
    set_row(8,  1, 1, 1, s1_bm,     0, '0,        0,  0);
    set_row(9,  0, 1, 1, zero_bm,   1, '0,        0,  0);
    set_row(10, 0, 1, 1, best32_bm, 1, '0,        32, 1);
    set_row(11, 0, 0, 0, best32_bm, 0, '0,        32, 1);

    model_reset();

    // Reset then ten idle cycles
    cyc(1, 0, 0, zero_bm);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, zero_bm);
      chk("idle.dec_valid",   64'(dec_valid),   64'd0);
      chk("idle.dec_bits",    64'(dec_bits),    64'd0);
      chk("idle.best_state",  64'(best_state),  64'd0);
      chk("idle.best_metric", 64'(best_metric), 64'd0);
    end

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].sof, tbl[i].bm);
      chk($sformatf("vec%0d.dec_valid", i),   64'(dec_valid),   64'(tbl[i].exp_dv));
      chk($sformatf("vec%0d.dec_bits", i),    64'(dec_bits),    64'(tbl[i].exp_dec));
      chk($sformatf("vec%0d.best_state", i),  64'(best_state),  64'(tbl[i].exp_bs));
      chk($sformatf("vec%0d.best_metric", i), 64'(best_metric), 64'(tbl[i].exp_bm));
    end

    // Uniform branch metric of 2: metrics climb by 2 per step until normalisation
    cyc(0, 1, 1, all2_bm);
    chk_model("norm1");
    for (int k = 2; k <= 33; k++) begin
      cyc(0, 1, 0, all2_bm);
      chk_model($sformatf("norm%0d", k));
      if (k == 6)  chk("norm.step6_metric",  64'(best_metric), 64'd12);
      if (k == 31) chk("norm.step31_metric", 64'(best_metric), 64'd62);
      if (k == 32) begin
        chk("norm.step32_metric", 64'(best_metric), 64'd0);
        chk("norm.step32_state",  64'(best_state),  64'd0);
        chk("norm.step32_dec",    64'(dec_bits),    64'd0);
      end
      if (k == 33) chk("norm.step33_metric", 64'(best_metric), 64'd2);
    end

    // Gapped stream: dec_valid follows in_valid, metrics match the gap-free model
    gap_v = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      rb = rand_bm();
      cyc(0, gap_v[i], (i == 0), rb);
      chk($sformatf("gap%0d.dec_valid", i), 64'(dec_valid), 64'(gap_v[i]));
      chk_model($sformatf("gap%0d", i));
    end

    // Randomized stream
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 19) == 0);
      rb = rand_bm();
      cyc(r, v, s, rb);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
